// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read/write, trap entry/return, interrupt arbitration, counters.
// Reads are combinational; every state change lands on the next rising CLK edge.
module csr_trap_unit #(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned COUNTER_W     = 64,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100,
  parameter logic [31:0] HART_ID       = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        csr_write,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        csr_exception,
  input  logic [31:0] csr_exception_cause,
  input  logic [31:0] csr_exception_pc,
  input  logic [31:0] csr_exception_tval,
  input  logic        irq_ack,
  input  logic        mret,
  input  logic        instr_retire,
  input  logic        msip,
  input  logic        mtip,
  input  logic        meip,
  input  logic [(NUM_LOCAL_IRQ > 0 ? NUM_LOCAL_IRQ : 1)-1:0] local_irq,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [31:0] trap_vector,
  output logic [31:0] mret_pc,
  output logic        csr_mie
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] IRQ_MASK =
    32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);

  logic                 mstatus_mie_q, mstatus_mpie_q;
  logic [31:0]          mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [31:0]          mip_d;
  logic [COUNTER_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [63:0] cyc64, ret64, cyc_inc, ret_inc, cyc_full, ret_full;
  logic [31:0] irq_pend, tvec_base;
  logic [4:0]  irq_code;
  logic        wr_illegal, wr_ok, no_trap, cnt_wr;

  function automatic logic is_impl(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
      A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH, A_MHARTID: is_impl = 1'b1;
      default: is_impl = 1'b0;
    endcase
  endfunction

  assign wr_illegal  = csr_write & (~is_impl(csr_waddr) | (csr_waddr == A_MIP) |
                                    (csr_waddr == A_MHARTID));
  assign csr_illegal = ~is_impl(csr_raddr) | wr_illegal;
  assign wr_ok       = csr_write & ~wr_illegal;
  assign no_trap     = ~csr_exception & ~irq_ack;
  // Counter writes survive a concurrent mret; every other write is dropped by it.
  assign cnt_wr      = wr_ok & no_trap;

  assign cyc64 = 64'(mcycle_q);
  assign ret64 = 64'(minstret_q);

  always_comb begin
    mip_d     = '0;
    mip_d[3]  = msip;
    mip_d[7]  = mtip;
    mip_d[11] = meip;
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) mip_d[16+i] = local_irq[i];
  end

  // Later assignments win, so the checks run from lowest to highest priority.
  always_comb begin
    irq_pend = mip_q & mie_q;
    irq_code = 5'd11;
    for (int i = int'(NUM_LOCAL_IRQ) - 1; i >= 0; i--)
      if (irq_pend[16+i]) irq_code = 5'(16 + i);
    if (irq_pend[7])  irq_code = 5'd7;
    if (irq_pend[3])  irq_code = 5'd3;
    if (irq_pend[11]) irq_code = 5'd11;
  end

  assign irq_cause = {1'b1, 26'd0, irq_code};
  assign irq_req   = mstatus_mie_q & (|irq_pend);
  assign csr_mie   = mstatus_mie_q;
  assign mret_pc   = mepc_q;
  assign tvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_vector = tvec_base;
    if ((mtvec_q[1:0] == 2'b01) && irq_ack && !csr_exception)
      trap_vector = tvec_base + {25'd0, irq_code, 2'b00};
  end

  always_comb begin
    cyc_inc  = cyc64 + 64'd1;
    ret_inc  = ret64 + {63'd0, instr_retire};
    cyc_full = cyc_inc;
    ret_full = ret_inc;
    // A high-half write keeps the incremented low half but drops its carry.
    if (cnt_wr && csr_waddr == A_MCYCLE)    cyc_full = {cyc64[63:32], csr_wdata};
    if (cnt_wr && csr_waddr == A_MCYCLEH)   cyc_full = {csr_wdata, cyc_inc[31:0]};
    if (cnt_wr && csr_waddr == A_MINSTRET)  ret_full = {ret64[63:32], csr_wdata};
    if (cnt_wr && csr_waddr == A_MINSTRETH) ret_full = {csr_wdata, ret_inc[31:0]};
    mcycle_d   = cyc_full[COUNTER_W-1:0];
    minstret_d = ret_full[COUNTER_W-1:0];
  end

  always_comb begin
    case (csr_raddr)
      A_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MIE:       csr_rdata = mie_q;
      A_MTVEC:     csr_rdata = mtvec_q;
      A_MSCRATCH:  csr_rdata = mscratch_q;
      A_MEPC:      csr_rdata = mepc_q;
      A_MCAUSE:    csr_rdata = mcause_q;
      A_MTVAL:     csr_rdata = mtval_q;
      A_MIP:       csr_rdata = mip_q;
      A_MCYCLE:    csr_rdata = cyc64[31:0];
      A_MCYCLEH:   csr_rdata = cyc64[63:32];
      A_MINSTRET:  csr_rdata = ret64[31:0];
      A_MINSTRETH: csr_rdata = ret64[63:32];
      A_MHARTID:   csr_rdata = HART_ID;
      default:     csr_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mip_q          <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mip_q      <= mip_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (csr_exception) begin
        mepc_q         <= {csr_exception_pc[31:2], 2'b00};
        mcause_q       <= csr_exception_cause;
        mtval_q        <= csr_exception_tval;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (irq_ack) begin
        mepc_q         <= {csr_exception_pc[31:2], 2'b00};
        mcause_q       <= irq_cause;
        mtval_q        <= '0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (wr_ok) begin
        case (csr_waddr)
          A_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata[3];
            mstatus_mpie_q <= csr_wdata[7];
          end
          A_MIE:      mie_q      <= csr_wdata & IRQ_MASK;
          A_MTVEC:    mtvec_q    <= {csr_wdata[31:2],
                                     csr_wdata[1] ? mtvec_q[1:0] : csr_wdata[1:0]};
          A_MSCRATCH: mscratch_q <= csr_wdata;
          A_MEPC:     mepc_q     <= {csr_wdata[31:2], 2'b00};
          A_MCAUSE:   mcause_q   <= csr_wdata;
          A_MTVAL:    mtval_q    <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR access vector table plus trap, interrupt and counter sequences.
module tb_csr_trap_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        csr_write;
  logic [11:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata;
  logic        csr_exception, irq_ack, mret, instr_retire, msip, mtip, meip;
  logic [31:0] csr_exception_cause, csr_exception_pc, csr_exception_tval;
  logic [3:0]  local_irq;

  logic [31:0] csr_rdata, irq_cause, trap_vector, mret_pc;
  logic        csr_illegal, irq_req, csr_mie;
  logic [31:0] csr_rdata32, irq_cause32, trap_vector32, mret_pc32;
  logic        csr_illegal32, irq_req32, csr_mie32;

  int errors = 0;
  int checks = 0;

  always #10 CLK = ~CLK;

  csr_trap_unit #(.NUM_LOCAL_IRQ(4), .COUNTER_W(64), .MTVEC_RESET(32'h100), .HART_ID(32'h5)) u_dut (
    .CLK(CLK), .nRST(nRST), .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .csr_exception(csr_exception), .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc), .csr_exception_tval(csr_exception_tval),
    .irq_ack(irq_ack), .mret(mret), .instr_retire(instr_retire), .msip(msip), .mtip(mtip),
    .meip(meip), .local_irq(local_irq), .irq_req(irq_req), .irq_cause(irq_cause),
    .trap_vector(trap_vector), .mret_pc(mret_pc), .csr_mie(csr_mie));

  csr_trap_unit #(.NUM_LOCAL_IRQ(4), .COUNTER_W(32), .MTVEC_RESET(32'h100), .HART_ID(32'h5)) u_dut32 (
    .CLK(CLK), .nRST(nRST), .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata32), .csr_illegal(csr_illegal32),
    .csr_exception(csr_exception), .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc), .csr_exception_tval(csr_exception_tval),
    .irq_ack(irq_ack), .mret(mret), .instr_retire(instr_retire), .msip(msip), .mtip(mtip),
    .meip(meip), .local_irq(local_irq), .irq_req(irq_req32), .irq_cause(irq_cause32),
    .trap_vector(trap_vector32), .mret_pc(mret_pc32), .csr_mie(csr_mie32));

  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        ill;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_raddr = a;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  task automatic rd32(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_raddr = a;
    #1;
    chk(nm, csr_rdata32, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_write = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    step();
    csr_write = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 12'h000, 32'h0,        12'h300, 32'h0000_1800, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 32'h0,        12'hF14, 32'h0000_0005, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 32'h0,        12'h7C0, 32'h0000_0000, 1'b1};
    tbl[3]  = '{1'b0, 12'h000, 32'h0,        12'h305, 32'h0000_0100, 1'b0};
    tbl[4]  = '{1'b1, 12'h340, 32'hDEADBEEF, 12'h340, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 32'h0,        12'h340, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b1, 12'h341, 32'h1237,     12'h341, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 32'h0,        12'h341, 32'h0000_1234, 1'b0};
    tbl[8]  = '{1'b1, 12'h305, 32'h303,      12'h305, 32'h0000_0100, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 32'h0,        12'h305, 32'h0000_0300, 1'b0};
    tbl[10] = '{1'b1, 12'h305, 32'h102,      12'h304, 32'h0000_0000, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 32'h0,        12'h305, 32'h0000_0100, 1'b0};
    tbl[12] = '{1'b1, 12'h304, 32'hFFFFFFFF, 12'h305, 32'h0000_0100, 1'b0};
    tbl[13] = '{1'b0, 12'h000, 32'h0,        12'h304, 32'h000F_0888, 1'b0};
    tbl[14] = '{1'b1, 12'h344, 32'h1,        12'h344, 32'h0000_0000, 1'b1};
    tbl[15] = '{1'b1, 12'hF14, 32'h7,        12'hF14, 32'h0000_0005, 1'b1};
    tbl[16] = '{1'b1, 12'h7C0, 32'h1,        12'h300, 32'h0000_1800, 1'b1};
    tbl[17] = '{1'b1, 12'h304, 32'h0,        12'h304, 32'h000F_0888, 1'b0};
    tbl[18] = '{1'b0, 12'h000, 32'h0,        12'h304, 32'h0000_0000, 1'b0};
    tbl[19] = '{1'b1, 12'h300, 32'hFFFFFFFF, 12'h300, 32'h0000_1800, 1'b0};
    tbl[20] = '{1'b0, 12'h000, 32'h0,        12'h300, 32'h0000_1888, 1'b0};
    tbl[21] = '{1'b1, 12'h300, 32'h0,        12'h342, 32'h0000_0000, 1'b0};
    tbl[22] = '{1'b0, 12'h000, 32'h0,        12'h300, 32'h0000_1800, 1'b0};
    tbl[23] = '{1'b1, 12'h343, 32'hABCD,     12'h343, 32'h0000_0000, 1'b0};
    tbl[24] = '{1'b0, 12'h000, 32'h0,        12'h343, 32'h0000_ABCD, 1'b0};
    tbl[25] = '{1'b1, 12'hB02, 32'h0,        12'hB82, 32'h0000_0000, 1'b0};

    nRST = 1'b0; csr_write = 1'b0; csr_waddr = '0; csr_wdata = '0; csr_raddr = '0;
    csr_exception = 1'b0; csr_exception_cause = '0; csr_exception_pc = '0; csr_exception_tval = '0;
    irq_ack = 1'b0; mret = 1'b0; instr_retire = 1'b0; msip = 1'b0; mtip = 1'b0; meip = 1'b0;
    local_irq = '0;
    repeat (2) step();
    nRST = 1'b1;

    chk("rst_csr_mie", {31'd0, csr_mie}, 32'd0);
    chk("rst_irq_req", {31'd0, irq_req}, 32'd0);
    chk("rst_irq_cause", irq_cause, 32'h8000_000B);
    chk("rst_trap_vector", trap_vector, 32'h0000_0100);
    chk("rst_mret_pc", mret_pc, 32'd0);
    rd(12'hB00, 32'd0, "mcycle_0");
    step();
    rd(12'hB00, 32'd1, "mcycle_1");
    step();
    rd(12'hB00, 32'd2, "mcycle_2");

    for (int i = 0; i < 26; i++) begin
      csr_write = tbl[i].we;
      csr_waddr = tbl[i].waddr;
      csr_wdata = tbl[i].wdata;
      csr_raddr = tbl[i].raddr;
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].rdata);
      chk($sformatf("vec%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, tbl[i].ill});
      step();
      csr_write = 1'b0;
    end

    // Interrupt entry through MEI
    wr(12'h304, 32'h800);
    wr(12'h300, 32'h8);
    meip = 1'b1;
    #1 chk("irq_req_before_edge", {31'd0, irq_req}, 32'd0);
    step();
    chk("irq_req_meip", {31'd0, irq_req}, 32'd1);
    chk("irq_cause_meip", irq_cause, 32'h8000_000B);
    chk("csr_mie_set", {31'd0, csr_mie}, 32'd1);
    irq_ack = 1'b1; csr_exception_pc = 32'h2006;
    #1 chk("tvec_direct", trap_vector, 32'h100);
    step();
    irq_ack = 1'b0; meip = 1'b0; csr_exception_pc = '0;
    chk("irq_req_after_ack", {31'd0, irq_req}, 32'd0);
    chk("csr_mie_after_ack", {31'd0, csr_mie}, 32'd0);
    chk("mret_pc_after_ack", mret_pc, 32'h2004);
    rd(12'h341, 32'h2004, "mepc_irq");
    rd(12'h342, 32'h8000_000B, "mcause_irq");
    rd(12'h343, 32'h0, "mtval_irq");
    rd(12'h300, 32'h1880, "mstatus_irq");

    // mret with a dropped mscratch write
    mret = 1'b1; csr_write = 1'b1; csr_waddr = 12'h340; csr_wdata = 32'h1111;
    step();
    mret = 1'b0; csr_write = 1'b0;
    rd(12'h300, 32'h1888, "mstatus_mret");
    chk("csr_mie_mret", {31'd0, csr_mie}, 32'd1);
    rd(12'h340, 32'hDEADBEEF, "mscratch_dropped");
    chk("mret_pc", mret_pc, 32'h2004);

    // Vectored mode, then exception beats concurrent irq_ack
    wr(12'h305, 32'h201);
    wr(12'h304, 32'h80);
    mtip = 1'b1;
    step();
    chk("irq_req_mtip", {31'd0, irq_req}, 32'd1);
    chk("irq_cause_mtip", irq_cause, 32'h8000_0007);
    irq_ack = 1'b1;
    #1 chk("tvec_vectored", trap_vector, 32'h21C);
    csr_exception = 1'b1; csr_exception_cause = 32'd2;
    csr_exception_pc = 32'h3000; csr_exception_tval = 32'h55;
    #1 chk("tvec_exc_wins", trap_vector, 32'h200);
    step();
    irq_ack = 1'b0; csr_exception = 1'b0; mtip = 1'b0;
    csr_exception_cause = '0; csr_exception_pc = '0; csr_exception_tval = '0;
    rd(12'h342, 32'd2, "mcause_exc");
    rd(12'h341, 32'h3000, "mepc_exc");
    rd(12'h343, 32'h55, "mtval_exc");
    rd(12'h300, 32'h1880, "mstatus_exc");
    chk("tvec_idle", trap_vector, 32'h200);

    // Counter wrap across the low half, 64- and 32-bit builds
    wr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_wr");
    rd(12'hB80, 32'd0, "mcycleh_wr");
    rd32(12'hB80, 32'd0, "mcycleh32_wr");
    step();
    rd(12'hB00, 32'd0, "mcycle_carry");
    rd(12'hB80, 32'd1, "mcycleh_carry");
    rd32(12'hB00, 32'd0, "mcycle32_wrap");
    rd32(12'hB80, 32'd0, "mcycleh32_wrap");
    wr(12'hB80, 32'h7);
    rd(12'hB00, 32'd1, "mcycle_hiwr");
    rd(12'hB80, 32'd7, "mcycleh_hiwr");
    rd32(12'hB00, 32'd1, "mcycle32_hiwr");
    rd32(12'hB80, 32'd0, "mcycleh32_hiwr");

    // minstret: write overrides increment, then counts retires only
    instr_retire = 1'b1;
    wr(12'hB02, 32'd5);
    rd(12'hB02, 32'd5, "minstret_wr");
    step();
    rd(12'hB02, 32'd6, "minstret_inc");
    instr_retire = 1'b0;
    step();
    rd(12'hB02, 32'd6, "minstret_hold");
    csr_exception = 1'b1; csr_exception_cause = 32'd5; csr_exception_pc = 32'h4000;
    wr(12'hB02, 32'd100);
    csr_exception = 1'b0; csr_exception_cause = '0; csr_exception_pc = '0;
    rd(12'hB02, 32'd6, "minstret_trap_drop");
    rd(12'h342, 32'd5, "mcause_trap2");

    // Interrupt priority
    wr(12'h304, 32'h0001_0808);
    meip = 1'b1; msip = 1'b1; local_irq = 4'b0001;
    step();
    chk("prio_mei", irq_cause, 32'h8000_000B);
    rd(12'h344, 32'h0001_0808, "mip_read");
    meip = 1'b0;
    step();
    chk("prio_msi", irq_cause, 32'h8000_0003);
    msip = 1'b0;
    step();
    chk("prio_local0", irq_cause, 32'h8000_0010);
    local_irq = 4'b1010;
    wr(12'h304, 32'h000F_0000);
    chk("prio_local1", irq_cause, 32'h8000_0011);
    chk("irq_req_mie_off", {31'd0, irq_req}, 32'd0);
    local_irq = 4'b0000;

    // Reset arriving together with a trap discards the trap
    csr_exception = 1'b1; csr_exception_cause = 32'd9; csr_exception_pc = 32'h5000;
    nRST = 1'b0;
    step();
    nRST = 1'b1; csr_exception = 1'b0; csr_exception_cause = '0; csr_exception_pc = '0;
    rd(12'h342, 32'd0, "rst2_mcause");
    rd(12'h341, 32'd0, "rst2_mepc");
    rd(12'h300, 32'h1800, "rst2_mstatus");
    rd(12'h305, 32'h100, "rst2_mtvec");
    chk("rst2_trap_vector", trap_vector, 32'h100);
    chk("rst2_mret_pc", mret_pc, 32'd0);
    chk("rst2_irq_cause", irq_cause, 32'h8000_000B);
    chk("rst2_csr_mie", {31'd0, csr_mie}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
